// File: rtl/window_min_max_tracker.sv
// Windowed running min/max tracker with first-occurrence indices.
// Define SIGNED_COMPARE_EN for two's-complement compare (default unsigned).
module window_min_max_tracker #(
  parameter int DATA_WIDTH  = 32,
  parameter int WINDOW_LEN  = 16,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   Clock_In,
  input  logic                   Reset_In,
  input  logic                   Start_In,
  input  logic                   Data_Valid_In,
  input  logic [DATA_WIDTH-1:0]  Data_In,
  output logic                   Data_Ready_Out,
  output logic                   Busy_Out,
  output logic                   Done_Out,
  output logic [DATA_WIDTH-1:0]  Min_Out,
  output logic [DATA_WIDTH-1:0]  Max_Out,
  output logic [COUNT_WIDTH-1:0] Min_Index_Out,
  output logic [COUNT_WIDTH-1:0] Max_Index_Out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST =
    COUNT_WIDTH'(WINDOW_LEN - 1);

  state_t state;
  state_t state_nxt;

  logic [COUNT_WIDTH-1:0] count;
  logic xfer;
  logic last;
  logic first;
  logic lt_min;
  logic gt_max;

  assign Data_Ready_Out = (state == RUN);
  assign Busy_Out       = (state != IDLE);
  assign Done_Out       = (state == DONE);

  assign xfer  = Data_Valid_In & Data_Ready_Out;
  assign last  = (count == LAST);
  assign first = (count == '0);

`ifdef SIGNED_COMPARE_EN
  assign lt_min = $signed(Data_In) < $signed(Min_Out);
  assign gt_max = $signed(Data_In) > $signed(Max_Out);
`else
  assign lt_min = Data_In < Min_Out;
  assign gt_max = Data_In > Max_Out;
`endif

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (Start_In) state_nxt = RUN;
      RUN:  if (xfer && last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter holds at terminal count so it can never wrap.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      count <= '0;
    end else if (state == IDLE && Start_In) begin
      count <= '0;
    end else if (xfer && !last) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      Min_Out       <= '0;
      Max_Out       <= '0;
      Min_Index_Out <= '0;
      Max_Index_Out <= '0;
    end else if (xfer) begin
      if (first) begin
        Min_Out       <= Data_In;
        Max_Out       <= Data_In;
        Min_Index_Out <= '0;
        Max_Index_Out <= '0;
      end else begin
        if (lt_min) begin
          Min_Out       <= Data_In;
          Min_Index_Out <= count;
        end
        if (gt_max) begin
          Max_Out       <= Data_In;
          Max_Index_Out <= count;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_min_max_tracker.sv
// Bench for window_min_max_tracker: vector table plus scoreboard
// on Done_Out, with hand sequences for reset, held start and WINDOW_LEN=1.
module tb_window_min_max_tracker;

  logic clk;
  logic rst;

  logic        start4, valid4;
  logic [31:0] data4;
  logic        ready4, busy4, done4;
  logic [31:0] min4, max4;
  logic [4:0]  mni4, mxi4;

  logic        start1, valid1;
  logic [31:0] data1;
  logic        ready1, busy1, done1;
  logic [31:0] min1, max1;
  logic [4:0]  mni1, mxi1;

  int checks;
  int errors;
  int n_done;
  int exp_done;

  typedef struct {
    logic [3:0][31:0] s;
    logic [3:0][3:0]  gap;
    logic [31:0]      mn;
    logic [31:0]      mx;
    logic [4:0]       mni;
    logic [4:0]       mxi;
  } vec_t;

  typedef struct {
    logic [31:0] mn;
    logic [31:0] mx;
    logic [4:0]  mni;
    logic [4:0]  mxi;
  } exp_t;

  vec_t vt[6];
  exp_t sb[$];

  window_min_max_tracker #(
    .DATA_WIDTH (32),
    .WINDOW_LEN (4),
    .COUNT_WIDTH(5)
  ) dut4 (
    .Clock_In      (clk),
    .Reset_In      (rst),
    .Start_In      (start4),
    .Data_Valid_In (valid4),
    .Data_In       (data4),
    .Data_Ready_Out(ready4),
    .Busy_Out      (busy4),
    .Done_Out      (done4),
    .Min_Out       (min4),
    .Max_Out       (max4),
    .Min_Index_Out (mni4),
    .Max_Index_Out (mxi4)
  );

  window_min_max_tracker #(
    .DATA_WIDTH (32),
    .WINDOW_LEN (1),
    .COUNT_WIDTH(5)
  ) dut1 (
    .Clock_In      (clk),
    .Reset_In      (rst),
    .Start_In      (start1),
    .Data_Valid_In (valid1),
    .Data_In       (data1),
    .Data_Ready_Out(ready1),
    .Busy_Out      (busy1),
    .Done_Out      (done1),
    .Min_Out       (min1),
    .Max_Out       (max1),
    .Min_Index_Out (mni1),
    .Max_Index_Out (mxi1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic [31:0] a, b, c, d,
    input logic [3:0]  g1, g2, g3,
    input logic [31:0] mn, input logic [4:0] mni,
    input logic [31:0] mx, input logic [4:0] mxi);
    vec_t v;
    v.s[0] = a;  v.s[1] = b;
    v.s[2] = c;  v.s[3] = d;
    v.gap[0] = '0; v.gap[1] = g1;
    v.gap[2] = g2; v.gap[3] = g3;
    v.mn = mn; v.mni = mni;
    v.mx = mx; v.mxi = mxi;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && done4) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done got 1 want 0");
      end else begin
        e = sb.pop_front();
        chk("sb_min", min4, e.mn);
        chk("sb_max", max4, e.mx);
        chk("sb_min_idx", 32'(mni4), 32'(e.mni));
        chk("sb_max_idx", 32'(mxi4), 32'(e.mxi));
      end
    end
  end

  task automatic run_win(input vec_t v,
                         input bit do_start,
                         input bit hold);
    exp_t e;
    if (do_start) begin
      start4 = 1'b1;
      step();
      if (!hold) start4 = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      valid4 = 1'b0;
      for (int g = 0; g < int'(v.gap[i]); g++) step();
      valid4 = 1'b1;
      data4  = v.s[i];
      if (i == 3) begin
        e.mn = v.mn; e.mx = v.mx;
        e.mni = v.mni; e.mxi = v.mxi;
        sb.push_back(e);
        exp_done++;
      end
      step();
    end
    valid4 = 1'b0;
    chk("done_after_last", 32'(done4), 32'd1);
    chk("ready_in_done", 32'(ready4), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    n_done = 0; exp_done = 0;
    rst = 1'b1;
    start4 = 1'b0; valid4 = 1'b0; data4 = '0;
    start1 = 1'b0; valid1 = 1'b0; data1 = '0;

    vt[0] = mk(32'd5, 32'd9, 32'd2, 32'd9, 4'd0, 4'd0, 4'd0,
               32'd2, 5'd2, 32'd9, 5'd1);
    vt[1] = mk(32'd7, 32'd3, 32'd8, 32'd1, 4'd3, 4'd1, 4'd0,
               32'd1, 5'd3, 32'd8, 5'd2);
`ifdef SIGNED_COMPARE_EN
    vt[2] = mk(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0,
               32'hFFFF_FFFF, 5'd0, 32'd1, 5'd1);
    vt[5] = mk(32'h8000_0000, 32'h7FFF_FFFF, 32'd3, 32'h8000_0000,
               4'd0, 4'd2, 4'd0,
               32'h8000_0000, 5'd0, 32'h7FFF_FFFF, 5'd1);
`else
    vt[2] = mk(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0,
               32'd0, 5'd2, 32'hFFFF_FFFF, 5'd0);
    vt[5] = mk(32'h8000_0000, 32'h7FFF_FFFF, 32'd3, 32'h8000_0000,
               4'd0, 4'd2, 4'd0,
               32'd3, 5'd2, 32'h8000_0000, 5'd0);
`endif
    vt[3] = mk(32'd4, 32'd4, 32'd4, 32'd4, 4'd0, 4'd0, 4'd0,
               32'd4, 5'd0, 32'd4, 5'd0);
    vt[4] = mk(32'd10, 32'd20, 32'd30, 32'd40, 4'd0, 4'd1, 4'd0,
               32'd10, 5'd0, 32'd40, 5'd3);

    repeat (2) step();
    chk("rst_ready", 32'(ready4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_min", min4, 32'd0);
    chk("rst_max", max4, 32'd0);
    chk("rst_min_idx", 32'(mni4), 32'd0);
    chk("rst_max_idx", 32'(mxi4), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_ready", 32'(ready4), 32'd0);

    start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk("run_ready", 32'(ready4), 32'd1);
    chk("run_busy", 32'(busy4), 32'd1);
    run_win(vt[0], 1'b0, 1'b0);
    step();
    chk("done_one_cycle", 32'(done4), 32'd0);

    for (int k = 1; k < 6; k++) begin
      run_win(vt[k], 1'b1, 1'b0);
      step();
      chk("idle_after_done", 32'(busy4), 32'd0);
      chk("persist_min", min4, vt[k].mn);
      chk("persist_max", max4, vt[k].mx);
    end

    // Reset in the middle of a window.
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    valid4 = 1'b1;
    data4 = 32'd10; step();
    data4 = 32'd3;  step();
    valid4 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(ready4), 32'd0);
    chk("midrst_busy", 32'(busy4), 32'd0);
    chk("midrst_min", min4, 32'd0);
    chk("midrst_max", max4, 32'd0);
    step();
    rst = 1'b0;
    step();
    run_win(vt[0], 1'b1, 1'b0);
    step();

    // Start held high across RUN and DONE.
    run_win(vt[4], 1'b1, 1'b1);
    step();
    chk("held_idle_busy", 32'(busy4), 32'd0);
    chk("held_idle_done", 32'(done4), 32'd0);
    step();
    chk("held_rerun_busy", 32'(busy4), 32'd1);
    chk("held_rerun_ready", 32'(ready4), 32'd1);
    start4 = 1'b0;
    run_win(vt[1], 1'b0, 1'b0);
    step();

    // Single-sample window.
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    valid1 = 1'b1;
    data1 = 32'd42;
    step();
    valid1 = 1'b0;
    chk("w1_done", 32'(done1), 32'd1);
    chk("w1_min", min1, 32'd42);
    chk("w1_max", max1, 32'd42);
    chk("w1_min_idx", 32'(mni1), 32'd0);
    chk("w1_max_idx", 32'(mxi1), 32'd0);
    step();
    chk("w1_done_drop", 32'(done1), 32'd0);
    chk("w1_idle", 32'(busy1), 32'd0);

    repeat (2) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(exp_done));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
